// File: rtl/io_pkg.sv
// Shared constants for the UART-facing I/O responder and its FIFOs.
package io_pkg;

    localparam int IO_FIFO_DEPTH = 16;
    localparam int IO_BYTE_W     = 8;
    localparam int IO_WORD_W     = 32;

    // Widen a byte to the core's word width with zero fill.
    function automatic logic [IO_WORD_W-1:0] zext_byte(input logic [IO_BYTE_W-1:0] b);
        return {{(IO_WORD_W-IO_BYTE_W){1'b0}}, b};
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Single-clock synchronous FIFO with combinational head output.
// full/empty come from the registered occupancy only, so a pop in the same
// cycle never makes room for a push, and a push into an empty FIFO becomes
// visible at the head one cycle later.
module io_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/io_responder.sv
// Core-side byte I/O responder bridging a stalling core port to a UART.
// TX path: core writes -> TX FIFO -> valid/ready transmitter.
// RX path: receiver strobe -> RX FIFO -> core reads; drops set a sticky flag.
// Optional feature: define IO_STATS_EN to add tx_byte_count/rx_byte_count.
// Handshake: a TX byte moves when tx_valid and tx_ready are both high at a
// rising edge; tx_data is held stable while tx_valid waits for tx_ready.
module io_responder
    import io_pkg::*;
#(
    parameter int FIFO_DEPTH = IO_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  out_issued,
    input  logic [IO_WORD_W-1:0]  out_data,
    output logic                  out_stall,
    input  logic                  in_issued,
    output logic [IO_WORD_W-1:0]  in_data,
    output logic                  in_stall,
    output logic [IO_BYTE_W-1:0]  tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [IO_BYTE_W-1:0]  rx_data,
    input  logic                  rx_valid,
    output logic                  rx_overflow
`ifdef IO_STATS_EN
    ,
    output logic [31:0]           tx_byte_count,
    output logic [31:0]           rx_byte_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [IO_BYTE_W-1:0]           tx_head;
    logic                           tx_full;
    logic                           tx_empty;
    logic [CW-1:0]                  unused_tx_count;
    logic [IO_BYTE_W-1:0]           rx_head;
    logic                           rx_full;
    logic                           rx_empty;
    logic [CW-1:0]                  unused_rx_count;
    logic [IO_WORD_W-IO_BYTE_W-1:0] unused_out_hi;
    logic                           rx_overflow_q, rx_overflow_d;

    assign unused_out_hi = out_data[IO_WORD_W-1:IO_BYTE_W];

    io_fifo #(.DEPTH(FIFO_DEPTH), .W(IO_BYTE_W)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_issued),
        .din   (out_data[IO_BYTE_W-1:0]),
        .pop   (tx_ready),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (unused_tx_count)
    );

    io_fifo #(.DEPTH(FIFO_DEPTH), .W(IO_BYTE_W)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (in_issued),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (unused_rx_count)
    );

    assign out_stall   = tx_full;
    assign tx_valid    = !tx_empty;
    assign tx_data     = tx_head;
    assign in_stall    = rx_empty;
    assign in_data     = zext_byte(rx_head);
    assign rx_overflow = rx_overflow_q;

    // Overflow latches on any strobe that finds the RX FIFO full.
    always_comb begin
        rx_overflow_d = rx_overflow_q | (rx_valid & rx_full);
    end

    // Sticky overflow register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_overflow_q <= 1'b0;
        else     rx_overflow_q <= rx_overflow_d;
    end

`ifdef IO_STATS_EN
    logic [31:0] tx_cnt_q, tx_cnt_d;
    logic [31:0] rx_cnt_q, rx_cnt_d;

    // Count bytes actually handed off or stored; dropped bytes are not counted.
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_valid && tx_ready) tx_cnt_d = tx_cnt_q + 32'd1;
        if (rx_valid && !rx_full) rx_cnt_d = rx_cnt_q + 32'd1;
    end

    // Statistics registers, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    assign tx_byte_count = tx_cnt_q;
    assign rx_byte_count = rx_cnt_q;
`endif

endmodule
